// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration interface.
// master modport: view of the bus masters (drive requests and bus strobes).
// slave modport : view of the arbiter (returns grants and status).
interface bus_arbiter_rr_if #(
   parameter int NUM_MASTERS = 4
);
   localparam int AW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0] request;
   logic [NUM_MASTERS-1:0] grant;
   logic                   beginTransactionIn;
   logic                   endTransactionIn;
   logic                   busErrorIn;
   logic                   endTransactionOut;
   logic                   busErrorOut;
   logic [AW-1:0]          activeMaster;
   logic                   busIdle;

   modport master (
      output request, beginTransactionIn, endTransactionIn, busErrorIn,
      input  grant, endTransactionOut, busErrorOut, activeMaster, busIdle
   );

   modport slave (
      input  request, beginTransactionIn, endTransactionIn, busErrorIn,
      output grant, endTransactionOut, busErrorOut, activeMaster, busIdle
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin shared-bus arbiter: one-cycle grant pulse, begin timeout,
// transaction tracking until the end strobe.
// Optional watchdog on ACTIVE enabled by defining ARB_WATCHDOG_EN.
module bus_arbiter_rr #(
   parameter int NUM_MASTERS    = 4,
   parameter int BEGIN_WAIT     = 15,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   bus_arbiter_rr_if.slave bus
);
   localparam int AW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int BW = $clog2(BEGIN_WAIT + 1);
   // WAIT_BEGIN gives up after BEGIN_WAIT cycles (counter runs 0..BEGIN_WAIT-1)
   localparam logic [BW-1:0] BEGIN_LAST = BW'(BEGIN_WAIT - 1);
   localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_MASTERS - 1);

   typedef enum logic [2:0] {IDLE, GRANT, WAIT_BEGIN, ACTIVE, FORCE_END} state_t;

   state_t        state, stateNext;
   logic [AW-1:0] ptr;
   logic [AW-1:0] curMaster;
   logic [AW-1:0] sel;
   logic          found;
   logic [BW-1:0] beginCnt;
   int            cand;

`ifdef ARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   // ACTIVE lasts at most TIMEOUT_CYCLES cycles (counter runs 0..TIMEOUT_CYCLES-1)
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
   logic [WW-1:0] wdCnt;
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

   // first requesting master at or after the pointer, wrapping around
   always_comb begin
      sel   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         if (!found && bus.request[cand[AW-1:0]]) begin
            found = 1'b1;
            sel   = cand[AW-1:0];
         end
      end
   end

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= stateNext;
   end

   // next-state decision
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:       if (found) stateNext = GRANT;
         GRANT:      stateNext = WAIT_BEGIN;
         WAIT_BEGIN: begin
            if (bus.beginTransactionIn && bus.endTransactionIn) stateNext = IDLE;
            else if (bus.beginTransactionIn)                    stateNext = ACTIVE;
            else if (beginCnt == BEGIN_LAST)                    stateNext = IDLE;
         end
         ACTIVE: begin
            if (bus.endTransactionIn || bus.busErrorIn) stateNext = IDLE;
`ifdef ARB_WATCHDOG_EN
            else if (wdCnt == WD_LAST)                  stateNext = FORCE_END;
`endif
         end
         FORCE_END:  stateNext = IDLE;
         default:    stateNext = IDLE;
      endcase
   end

   // arbitration pointer, granted master and begin-wait counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         curMaster <= '0;
         beginCnt  <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               curMaster <= sel;
               ptr       <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
            end
            GRANT:      beginCnt <= '0;
            WAIT_BEGIN: if (!bus.beginTransactionIn && beginCnt != BEGIN_LAST)
                           beginCnt <= beginCnt + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef ARB_WATCHDOG_EN
   // watchdog counter: cleared on begin, saturating count while ACTIVE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                           wdCnt <= '0;
      else if (state == WAIT_BEGIN && bus.beginTransactionIn) wdCnt <= '0;
      else if (state == ACTIVE && wdCnt != WD_LAST)         wdCnt <= wdCnt + 1'b1;
   end
`endif

   // outputs decoded from state so reset clears them asynchronously
   always_comb begin
      bus.grant = '0;
      if (state == GRANT) bus.grant[curMaster] = 1'b1;
      bus.busIdle      = (state == IDLE);
      bus.activeMaster = curMaster;
`ifdef ARB_WATCHDOG_EN
      bus.endTransactionOut = (state == FORCE_END);
      bus.busErrorOut       = (state == FORCE_END);
`else
      bus.endTransactionOut = 1'b0;
      bus.busErrorOut       = 1'b0;
`endif
   end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (NUM_MASTERS=4, BEGIN_WAIT=15, TIMEOUT_CYCLES=8).
module tb_bus_arbiter_rr;
   logic clock;
   logic reset;
   int   tests;
   int   fails;

   bus_arbiter_rr_if #(.NUM_MASTERS(4)) bus ();

   bus_arbiter_rr #(.NUM_MASTERS(4), .BEGIN_WAIT(15), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic waitGrant(output logic [3:0] g);
      bit ok;
      ok = 0;
      g  = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.grant != 4'b0) begin g = bus.grant; ok = 1; end
         else @(negedge clock);
      end
   endtask

   // called on the negedge where the grant is visible
   task automatic runTxn;
      @(negedge clock) bus.beginTransactionIn = 1'b1;
      @(negedge clock) begin bus.beginTransactionIn = 1'b0; bus.endTransactionIn = 1'b1; end
      @(negedge clock) bus.endTransactionIn = 1'b0;
   endtask

   task automatic doReset;
      @(negedge clock) reset = 1'b0;
      @(negedge clock) reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      bus.request = '0; bus.beginTransactionIn = 0; bus.endTransactionIn = 0; bus.busErrorIn = 0;
      @(negedge clock); @(negedge clock);
      tests++; if (bus.grant !== 4'b0) begin fails++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
      tests++; if (bus.busIdle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected 1", bus.busIdle); end
      tests++; if (bus.activeMaster !== 2'd0) begin fails++; $display("FAIL reset_master: got %0d expected 0", bus.activeMaster); end
      tests++; if ({bus.endTransactionOut, bus.busErrorOut} !== 2'b00) begin fails++;
         $display("FAIL reset_forced: got %b expected 00", {bus.endTransactionOut, bus.busErrorOut}); end
      reset = 1'b1;
   endtask

   task automatic test_single;
      @(negedge clock) bus.request = 4'b0100;
      @(negedge clock);
      tests++; if (bus.grant !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b expected 0100", bus.grant); end
      tests++; if (bus.activeMaster !== 2'd2) begin fails++; $display("FAIL single_master: got %0d expected 2", bus.activeMaster); end
      tests++; if (bus.busIdle !== 1'b0) begin fails++; $display("FAIL single_busy: got %b expected 0", bus.busIdle); end
      bus.request = '0;
      @(negedge clock);
      tests++; if (bus.grant !== 4'b0) begin fails++; $display("FAIL single_pulse: got %b expected 0000", bus.grant); end
      bus.beginTransactionIn = 1'b1;
      @(negedge clock) bus.beginTransactionIn = 1'b0;
      repeat (4) @(negedge clock);
      tests++; if (bus.busIdle !== 1'b0) begin fails++; $display("FAIL single_active: got %b expected 0", bus.busIdle); end
      bus.endTransactionIn = 1'b1;
      @(negedge clock) bus.endTransactionIn = 1'b0;
      tests++; if (bus.busIdle !== 1'b1) begin fails++; $display("FAIL single_end_idle: got %b expected 1", bus.busIdle); end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp [4];
      logic [3:0] g;
      exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b1000; exp[3] = 4'b0001;
      doReset();
      bus.request = 4'b1011;
      for (int k = 0; k < 4; k++) begin
         waitGrant(g);
         tests++; if (g !== exp[k]) begin fails++; $display("FAIL rr_grant%0d: got %b expected %b", k, g, exp[k]); end
         runTxn();
         tests++; if (bus.busIdle !== 1'b1 || bus.grant !== 4'b0) begin fails++;
            $display("FAIL rr_turnaround%0d: got idle=%b grant=%b expected idle=1 grant=0000", k, bus.busIdle, bus.grant); end
      end
      bus.request = '0;
      @(negedge clock);
      if (bus.grant != 4'b0) runTxn();
   endtask

   task automatic test_begin_timeout;
      logic [3:0] g;
      int n;
      doReset();
      bus.request = 4'b0001;
      waitGrant(g);
      bus.request = '0;
      runTxn();
      bus.request = 4'b0011;
      @(negedge clock);
      waitGrant(g);
      tests++; if (g !== 4'b0010) begin fails++; $display("FAIL bto_grant1: got %b expected 0010", g); end
      n = 0;
      @(negedge clock);
      while (bus.busIdle == 1'b0 && n < 40) begin n++; @(negedge clock); end
      tests++; if (n !== 15) begin fails++; $display("FAIL bto_wait_cycles: got %0d expected 15", n); end
      waitGrant(g);
      tests++; if (g !== 4'b0001) begin fails++; $display("FAIL bto_next_grant: got %b expected 0001", g); end
      bus.request = '0;
      runTxn();
   endtask

   task automatic test_watchdog;
      logic [3:0] g;
      int n;
      bit bad;
      bus.request = 4'b0001;
      waitGrant(g);
      bus.request = '0;
      @(negedge clock) bus.beginTransactionIn = 1'b1;
      @(negedge clock) bus.beginTransactionIn = 1'b0;
`ifdef ARB_WATCHDOG_EN
      n = 0;
      while (bus.endTransactionOut == 1'b0 && n < 50) begin n++; @(negedge clock); end
      tests++; if (n !== 8) begin fails++; $display("FAIL wd_delay: got %0d expected 8", n); end
      tests++; if (bus.busErrorOut !== 1'b1) begin fails++; $display("FAIL wd_error: got %b expected 1", bus.busErrorOut); end
      @(negedge clock);
      tests++; if ({bus.endTransactionOut, bus.busErrorOut, bus.busIdle} !== 3'b001) begin fails++;
         $display("FAIL wd_release: got %b expected 001", {bus.endTransactionOut, bus.busErrorOut, bus.busIdle}); end
`else
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.endTransactionOut !== 1'b0 || bus.busErrorOut !== 1'b0 || bus.busIdle !== 1'b0) bad = 1;
         @(negedge clock);
      end
      tests++; if (bad) begin fails++; $display("FAIL nowd_hold: got forced/idle activity expected ACTIVE with outputs 0"); end
      n = 0;
      bus.endTransactionIn = 1'b1;
      @(negedge clock) bus.endTransactionIn = 1'b0;
      tests++; if (bus.busIdle !== 1'b1) begin fails++; $display("FAIL nowd_end: got %b expected 1", bus.busIdle); end
`endif
   endtask

   task automatic test_slave_error;
      logic [3:0] g;
      bus.request = 4'b0001;
      waitGrant(g);
      bus.request = '0;
      @(negedge clock) bus.beginTransactionIn = 1'b1;
      @(negedge clock) begin bus.beginTransactionIn = 1'b0; bus.busErrorIn = 1'b1; end
      @(negedge clock) bus.busErrorIn = 1'b0;
      tests++; if (bus.busIdle !== 1'b1) begin fails++; $display("FAIL serr_idle: got %b expected 1", bus.busIdle); end
      tests++; if ({bus.endTransactionOut, bus.busErrorOut} !== 2'b00) begin fails++;
         $display("FAIL serr_forced: got %b expected 00", {bus.endTransactionOut, bus.busErrorOut}); end
   endtask

   task automatic test_reset_mid;
      logic [3:0] g;
      bus.request = 4'b0100;
      waitGrant(g);
      bus.request = '0;
      @(negedge clock) bus.beginTransactionIn = 1'b1;
      @(negedge clock) bus.beginTransactionIn = 1'b0;
      tests++; if (bus.activeMaster !== 2'd2 || bus.busIdle !== 1'b0) begin fails++;
         $display("FAIL rmid_pre: got master=%0d idle=%b expected master=2 idle=0", bus.activeMaster, bus.busIdle); end
      #2 reset = 1'b0;
      #1;
      tests++; if (bus.grant !== 4'b0 || bus.busIdle !== 1'b1 || bus.activeMaster !== 2'd0) begin fails++;
         $display("FAIL rmid_async: got grant=%b idle=%b master=%0d expected 0000/1/0", bus.grant, bus.busIdle, bus.activeMaster); end
      @(negedge clock) begin reset = 1'b1; bus.request = 4'b0001; end
      waitGrant(g);
      tests++; if (g !== 4'b0001) begin fails++; $display("FAIL rmid_regrant: got %b expected 0001", g); end
      bus.request = '0;
      runTxn();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_begin_timeout();
      test_watchdog();
      test_slave_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
